// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage between execute and DataMem.
// Takes one load/store per request handshake and drives the DataMem pins.
// Aligned accesses use one memory cycle. Misaligned accesses are split into
// byte accesses, or fault when SPLIT_EN = 0. Illegal requests fault without
// touching memory. Load data comes back sign- or zero-extended.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   ReqValid/ReqReady             request handshake
//   ReqWrite, ReqFunct3           store flag and RISC-V funct3
//   ReqAddr, ReqWData             byte address and store data
//   RespValid                     one-cycle completion pulse
//   RespRData, RespFault          extended load data and fault flag
//   MemRead, MemWrite, MemAddr,
//   MemWData, MemFunct3           DataMem control, address, data, size
//   MemRData                      DataMem combinational read data
module load_store_unit #(
  parameter int unsigned ADDR_W   = 6,
  parameter bit          SPLIT_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic              ReqWrite,
  input  logic [2:0]        ReqFunct3,
  input  logic [31:0]       ReqAddr,
  input  logic [31:0]       ReqWData,
  output logic              RespValid,
  output logic [31:0]       RespRData,
  output logic              RespFault,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [31:0]       MemWData,
  output logic [2:0]        MemFunct3,
  input  logic [31:0]       MemRData
);

  localparam int unsigned BYTE_W = 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    SPLIT  = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  // Registered request and result
  logic              ready_q;
  logic              wr_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [1:0]        k_q;
  logic [31:0]       rdata_q;
  logic              fault_q;

  // Request decode
  logic        accept_c;
  logic [2:0]  size_c;
  logic        legal_c;
  logic [32:0] last_c;
  logic        range_ok_c;
  logic        misaligned_c;
  logic        fault_c;
  logic [1:0]  last_k_c;
  logic [31:0] ext_c;

  assign accept_c = ReqValid & ready_q;
  assign ReqReady = ready_q;

  // Access size in bytes and legality of the requested funct3
  always_comb begin
    size_c  = 3'd4;
    legal_c = 1'b0;
    case (ReqFunct3[1:0])
      2'b00:   size_c = 3'd1;
      2'b01:   size_c = 3'd2;
      default: size_c = 3'd4;
    endcase
    if (ReqWrite) begin
      legal_c = (ReqFunct3 == F3_B) || (ReqFunct3 == F3_H) || (ReqFunct3 == F3_W);
    end else begin
      legal_c = (ReqFunct3 == F3_B) || (ReqFunct3 == F3_H) || (ReqFunct3 == F3_W) ||
                (ReqFunct3 == F3_BU) || (ReqFunct3 == F3_HU);
    end
  end

  // Last byte touched must lie inside memory; 33 bits so no wrap-around
  assign last_c       = {1'b0, ReqAddr} + 33'(size_c) - 33'd1;
  assign range_ok_c   = (last_c >> ADDR_W) == 33'd0;
  assign misaligned_c = ((ReqFunct3[1:0] == 2'b01) && ReqAddr[0]) ||
                        ((ReqFunct3[1:0] == 2'b10) && (ReqAddr[1:0] != 2'b00));
  assign fault_c      = !legal_c || !range_ok_c || (misaligned_c && !SPLIT_EN);

  // Final byte index of a split access: half = 1, word = 3
  assign last_k_c = (f3_q[1:0] == 2'b01) ? 2'd1 : 2'd3;

  // Extension of the assembled load data
  always_comb begin
    ext_c = rdata_q;
    case (f3_q)
      F3_B:    ext_c = {{24{rdata_q[7]}}, rdata_q[7:0]};
      F3_H:    ext_c = {{16{rdata_q[15]}}, rdata_q[15:0]};
      F3_BU:   ext_c = {24'd0, rdata_q[7:0]};
      F3_HU:   ext_c = {16'd0, rdata_q[15:0]};
      default: ext_c = rdata_q;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept_c) begin
          if (fault_c) begin
            state_next = RESP;
          end else if (misaligned_c) begin
            state_next = SPLIT;
          end else begin
            state_next = ACCESS;
          end
        end
      end
      ACCESS: state_next = RESP;
      SPLIT: begin
        if (k_q == last_k_c) begin
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request capture, byte counter and load-data assembly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q <= 1'b0;
      wr_q    <= 1'b0;
      f3_q    <= F3_W;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      k_q     <= 2'd0;
      rdata_q <= 32'd0;
      fault_q <= 1'b0;
    end else begin
      // Ready mirrors "next cycle is IDLE" so it is low for the whole busy window
      ready_q <= (state_next == IDLE);
      if (accept_c) begin
        wr_q    <= ReqWrite;
        f3_q    <= ReqFunct3;
        addr_q  <= ReqAddr[ADDR_W-1:0];
        wdata_q <= ReqWData;
        k_q     <= 2'd0;
        rdata_q <= 32'd0;
        fault_q <= fault_c;
      end
      if ((state == ACCESS) && !wr_q) begin
        rdata_q <= MemRData;
      end
      if (state == SPLIT) begin
        k_q <= k_q + 2'd1;
        if (!wr_q) begin
          rdata_q[{k_q, 3'b000} +: BYTE_W] <= MemRData[BYTE_W-1:0];
        end
      end
    end
  end

  // Output logic
  always_comb begin
    RespValid = 1'b0;
    RespRData = 32'd0;
    RespFault = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    MemAddr   = '0;
    MemWData  = 32'd0;
    MemFunct3 = F3_W;
    case (state)
      ACCESS: begin
        MemRead   = !wr_q;
        MemWrite  = wr_q;
        MemAddr   = addr_q;
        MemWData  = wdata_q;
        MemFunct3 = f3_q;
      end
      SPLIT: begin
        MemRead   = !wr_q;
        MemWrite  = wr_q;
        MemAddr   = addr_q + ADDR_W'(k_q);
        MemFunct3 = wr_q ? F3_B : F3_BU;
        if (wr_q) begin
          MemWData = {24'd0, wdata_q[{k_q, 3'b000} +: BYTE_W]};
        end
      end
      RESP: begin
        RespValid = 1'b1;
        RespFault = fault_q;
        RespRData = (fault_q || wr_q) ? 32'd0 : ext_c;
      end
      default: ;
    endcase
  end

endmodule
